rpn_job_arbiter: RTL and testbench
==================================

Name: rpn_job_arbiter

Overview:
Shares one programmable RPN calculator (code RAM plus steering FSM, interface datain/addr/wr/start/ready/out) between two requesters.
- A granted requester streams a program into the calculator's code memory over a valid/ready handshake.
- The arbiter then starts execution, waits for completion and returns the result word plus a run-cycle count.
- Grants are round-robin. One job is in flight at a time.

Parameters:
N, 16, operand/instruction width (matches calculator N)
M, 10, code address width (matches calculator M)
C, 16, width of run-cycle counter

Ports:
clk  in  1  clock
nrst  in  1  asynchronous reset, active-low
req_valid  in  2  per-requester program word valid
req0_word  in  N  requester 0 program word
req1_word  in  N  requester 1 program word
req_last  in  2  per-requester last-word flag, qualified by req_valid
req_ready  out  2  per-requester word accept
resp_valid  out  2  per-requester result valid
resp_ready  in  2  per-requester result accept
resp_data  out  N  result (calculator out), shared
resp_cycles  out  C  RUN-state cycle count, saturating, shared
grant  out  1  index of current/last owner
busy  out  1  high in any state except IDLE
calc_datain  out  N  to calculator datain
calc_addr  out  M  to calculator addr
calc_wr  out  1  to calculator wr
calc_start  out  1  to calculator start
calc_ready  in  1  from calculator ready
calc_out  in  N  from calculator out

Behaviour:
- Reset (async, nrst low): state IDLE; all outputs 0; last_grant=1 so requester 0 wins the first tie; load address=0; resp_data=0; resp_cycles=0.
- States: IDLE, LOAD, START, RUN, RESP.
- IDLE:
  - If any req_valid and calc_ready=1, grant the sole valid requester. If both are valid, grant the one != last_grant.
  - Register grant, clear load address, go to LOAD next cycle.
  - req_ready=0 in IDLE, so no word is consumed in the grant cycle.
- LOAD:
  - req_ready[grant]=1, the other bit 0.
  - On req_valid[grant]&req_ready[grant]: calc_wr=1, calc_addr=load address, calc_datain=granted word (combinational from the granted requester); load address increments.
  - Transaction with req_last=1, or at address 2^M-1: go to START. The word at address 2^M-1 is treated as last; further words stay unaccepted until the next grant.
  - req_valid low: stall, no write.
  - calc_start=0 throughout LOAD, so the calculator accepts every write.
- START:
  - calc_start=1 for exactly one cycle; cycle counter cleared; go to RUN.
- RUN:
  - Counter increments each cycle, saturating at 2^C-1.
  - The first RUN cycle ignores calc_ready, because the calculator's ready falls only on the edge after start.
  - From the second RUN cycle on, calc_ready=1 means the calculator has finished: capture resp_data<=calc_out and resp_cycles<=counter, then go to RESP.
- RESP:
  - resp_valid[grant]=1 until resp_ready[grant]=1.
  - On the handshake: last_grant<=grant, go to IDLE.
  - resp_data/resp_cycles hold until the next capture.
- The non-granted requester never sees req_ready or resp_valid high; it may hold req_valid indefinitely.
- Empty program: a single word with req_last=1 is legal.
- No timeout: a non-terminating program keeps the arbiter in RUN until reset.
- Reset mid-operation: immediate return to IDLE; a partially loaded program is discarded. The calculator shares nrst, so it is also reset.
- calc_wr is never asserted outside LOAD; calc_start is never asserted outside START.

Test Plan:
- Reset, then req0 sends 3 words (push 5, push 7, finish opcode with top bits 11) with req_last on word 3 -> writes to addr 0,1,2; one calc_start pulse; resp_valid[0]=1; resp_data=calculator top; resp_cycles equals measured RUN length.
- Both req_valid high from reset -> requester 0 served first, then requester 1. Repeat with both high -> 0,1,0,1 order; grant never repeats while the other is waiting.
- req0 drops req_valid for 4 cycles mid-load -> no calc_wr in those cycles; addresses stay contiguous; result unchanged.
- Program with 2^M words and no req_last -> word at addr 2^M-1 accepted and treated as last; next word not accepted (req_ready=0); START follows.
- resp_ready held low for 10 cycles -> resp_valid stays high, data stable, no new grant; releasing it -> IDLE, next grant one cycle later.
- nrst pulsed low during LOAD after 2 words -> outputs 0 immediately, busy=0; a fresh job from requester 1 then completes normally from addr 0.

Source files
------------

// File: rtl/rpn_job_arbiter_if.sv
// Requester-side bundle of the RPN job arbiter: program-word stream in,
// result words and status out.
interface rpn_job_arbiter_if #(
    parameter int N = 16,
    parameter int C = 16
);
    logic [1:0]   req_valid;
    logic [N-1:0] req0_word;
    logic [N-1:0] req1_word;
    logic [1:0]   req_last;
    logic [1:0]   req_ready;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [N-1:0] resp_data;
    logic [C-1:0] resp_cycles;
    logic         grant;
    logic         busy;

    // Requester side
    modport master (
        output req_valid, req0_word, req1_word, req_last, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_cycles, grant, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req0_word, req1_word, req_last, resp_ready,
        output req_ready, resp_valid, resp_data, resp_cycles, grant, busy
    );
endinterface

// File: rtl/rpn_job_arbiter.sv
// Round-robin arbiter sharing one RPN calculator between two requesters:
// load program, start, wait for completion, return result and run length.
module rpn_job_arbiter #(
    parameter int N = 16,
    parameter int M = 10,
    parameter int C = 16
) (
    input  logic          clk,
    input  logic          nrst,
    rpn_job_arbiter_if.slave jif,
    output logic [N-1:0]  calc_datain,
    output logic [M-1:0]  calc_addr,
    output logic          calc_wr,
    output logic          calc_start,
    input  logic          calc_ready,
    input  logic [N-1:0]  calc_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t       state_r;
    logic         grant_r;
    logic         last_grant_r;
    logic         first_run_r;
    logic         calc_start_r;
    logic         busy_r;
    logic [M-1:0] load_addr_r;
    logic [1:0]   req_ready_r;
    logic [1:0]   resp_valid_r;
    logic [C-1:0] cnt_r;
    logic [N-1:0] resp_data_r;
    logic [C-1:0] resp_cycles_r;

    logic         wr_s;
    logic         pick_s;
    logic         last_word_s;
    logic [N-1:0] word_s;
    logic [C-1:0] cnt_inc_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Write strobe, granted word, tie-break choice and saturating counter step
    always_comb begin
        wr_s        = |(jif.req_valid & req_ready_r);
        word_s      = grant_r ? jif.req1_word : jif.req0_word;
        last_word_s = jif.req_last[grant_r] || (load_addr_r == {M{1'b1}});
        if (jif.req_valid == 2'b11) begin
            pick_s = ~last_grant_r;
        end else begin
            pick_s = jif.req_valid[1];
        end
        if (cnt_r == {C{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(C-1){1'b0}}, 1'b1};
        end
    end

    // Job sequencing; resp_cycles takes the stepped count so it equals the
    // number of RUN cycles including the completion cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r       <= ST_IDLE;
            grant_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            first_run_r   <= 1'b0;
            calc_start_r  <= 1'b0;
            busy_r        <= 1'b0;
            load_addr_r   <= {M{1'b0}};
            req_ready_r   <= 2'b00;
            resp_valid_r  <= 2'b00;
            cnt_r         <= {C{1'b0}};
            resp_data_r   <= {N{1'b0}};
            resp_cycles_r <= {C{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((|jif.req_valid) && calc_ready) begin
                        grant_r     <= pick_s;
                        load_addr_r <= {M{1'b0}};
                        req_ready_r <= onehot2(pick_s);
                        busy_r      <= 1'b1;
                        state_r     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr_s) begin
                        load_addr_r <= load_addr_r + {{(M-1){1'b0}}, 1'b1};
                        if (last_word_s) begin
                            req_ready_r  <= 2'b00;
                            calc_start_r <= 1'b1;
                            state_r      <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    calc_start_r <= 1'b0;
                    cnt_r        <= {C{1'b0}};
                    first_run_r  <= 1'b1;
                    state_r      <= ST_RUN;
                end
                ST_RUN: begin
                    // ready drops one edge late, so the first RUN cycle is blind
                    first_run_r <= 1'b0;
                    cnt_r       <= cnt_inc_s;
                    if (!first_run_r && calc_ready) begin
                        resp_data_r   <= calc_out;
                        resp_cycles_r <= cnt_inc_s;
                        resp_valid_r  <= onehot2(grant_r);
                        state_r       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (jif.resp_ready[grant_r]) begin
                        resp_valid_r <= 2'b00;
                        last_grant_r <= grant_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 2'b00;
                    resp_valid_r <= 2'b00;
                    calc_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign jif.req_ready   = req_ready_r;
    assign jif.resp_valid  = resp_valid_r;
    assign jif.resp_data   = resp_data_r;
    assign jif.resp_cycles = resp_cycles_r;
    assign jif.grant       = grant_r;
    assign jif.busy        = busy_r;

    assign calc_wr     = wr_s;
    assign calc_addr   = wr_s ? load_addr_r : {M{1'b0}};
    assign calc_datain = wr_s ? word_s : {N{1'b0}};
    assign calc_start  = calc_start_r;

endmodule

// File: tb/tb_rpn_job_arbiter.sv
// Randomized bench for rpn_job_arbiter: behavioural job model, fake
// calculator returning a position-weighted sum of its code memory.
module tb_rpn_job_arbiter;
    localparam int N     = 16;
    localparam int M     = 10;
    localparam int C     = 6;
    localparam int DEPTH = 1 << M;
    localparam int SAT   = (1 << C) - 1;
    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_RUN = 3, P_RESP = 4;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    rpn_job_arbiter_if #(.N(N), .C(C)) jif ();
    logic [N-1:0] calc_datain;
    logic [M-1:0] calc_addr;
    logic         calc_wr;
    logic         calc_start;
    logic         calc_ready;
    logic [N-1:0] calc_out;

    rpn_job_arbiter #(.N(N), .M(M), .C(C)) dut (
        .clk(clk), .nrst(nrst), .jif(jif),
        .calc_datain(calc_datain), .calc_addr(calc_addr), .calc_wr(calc_wr),
        .calc_start(calc_start), .calc_ready(calc_ready), .calc_out(calc_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fake calculator: ready falls one edge after start, rises c_rem edges later
    logic [N-1:0] c_mem [DEPTH];
    int c_hi, c_phase, c_rem;
    int force_delay = 0;

    function automatic logic [N-1:0] mem_weighted(input int len);
        logic [31:0] acc = 32'd0;
        for (int a = 0; a < len; a++) acc = acc + 32'(c_mem[a]) * 32'(a + 1);
        return acc[N-1:0];
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            calc_ready <= 1'b1; calc_out <= '0; c_hi <= 0; c_phase <= 0; c_rem <= 0;
        end else begin
            if (calc_wr) begin
                c_mem[calc_addr] <= calc_datain;
                if (int'(calc_addr) + 1 > c_hi) c_hi <= int'(calc_addr) + 1;
            end
            if (calc_start) begin
                c_phase <= 1;
                c_rem   <= (force_delay > 0) ? force_delay : int'($urandom_range(1, 6));
            end else if (c_phase == 1) begin
                calc_ready <= 1'b0; c_phase <= 2;
            end else if (c_phase == 2) begin
                if (c_rem <= 1) begin
                    calc_ready <= 1'b1; calc_out <= mem_weighted(c_hi); c_hi <= 0; c_phase <= 0;
                end else begin
                    c_rem <= c_rem - 1;
                end
            end
        end
    end

    // Reference job model: who owns the calculator, how far the job got
    int m_stage, m_owner, m_last, m_n, m_run, m_cycles;
    logic [N-1:0] m_sum, m_data;

    function automatic logic [N-1:0] word_of(input int who);
        return (who == 1) ? jif.req1_word : jif.req0_word;
    endfunction

    function automatic bit exp_wr();
        return (m_stage == P_LOAD) && jif.req_valid[m_owner];
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_stage <= P_IDLE; m_owner <= 0; m_last <= 1; m_n <= 0; m_run <= 0;
            m_cycles <= 0; m_sum <= '0; m_data <= '0;
        end else begin
            case (m_stage)
                P_IDLE: if (jif.req_valid != 2'b00 && calc_ready) begin
                    m_owner <= (jif.req_valid == 2'b11) ? 1 - m_last : (jif.req_valid[1] ? 1 : 0);
                    m_n <= 0; m_sum <= '0; m_stage <= P_LOAD;
                end
                P_LOAD: if (jif.req_valid[m_owner]) begin
                    m_n   <= m_n + 1;
                    m_sum <= m_sum + N'(32'(word_of(m_owner)) * 32'(m_n + 1));
                    if (jif.req_last[m_owner] || m_n == DEPTH - 1) m_stage <= P_START;
                end
                P_START: begin m_run <= 0; m_stage <= P_RUN; end
                P_RUN: begin
                    m_run <= m_run + 1;
                    if (m_run >= 1 && calc_ready) begin
                        m_data   <= m_sum;
                        m_cycles <= (m_run + 1 > SAT) ? SAT : m_run + 1;
                        m_stage  <= P_RESP;
                    end
                end
                P_RESP: if (jif.resp_ready[m_owner]) begin m_last <= m_owner; m_stage <= P_IDLE; end
                default: m_stage <= P_IDLE;
            endcase
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    int glog[$];
    logic prev_busy = 1'b0;
    int n_start = 0;
    int n_rv0 = 0;
    always @(negedge clk) begin
        check("busy", 32'(jif.busy), 32'(m_stage != P_IDLE));
        check("grant", 32'(jif.grant), 32'(m_owner));
        check("req_ready", 32'(jif.req_ready), (m_stage == P_LOAD) ? ((m_owner == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("resp_valid", 32'(jif.resp_valid), (m_stage == P_RESP) ? ((m_owner == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("calc_start", 32'(calc_start), 32'(m_stage == P_START));
        check("calc_wr", 32'(calc_wr), 32'(exp_wr()));
        check("calc_addr", 32'(calc_addr), exp_wr() ? 32'(m_n) : 32'd0);
        check("calc_datain", 32'(calc_datain), exp_wr() ? 32'(word_of(m_owner)) : 32'd0);
        check("resp_data", 32'(jif.resp_data), 32'(m_data));
        check("resp_cycles", 32'(jif.resp_cycles), 32'(m_cycles));
        if (jif.busy && !prev_busy) glog.push_back(int'(jif.grant));
        prev_busy <= jif.busy;
        if (calc_start) n_start <= n_start + 1;
        if (jif.resp_valid[0]) n_rv0 <= n_rv0 + 1;
    end

    // Requester agents
    logic [N-1:0] prog [2][DEPTH+1];
    int r_len[2], r_idx[2], r_stall_at[2], r_stall_n[2], r_rdelay[2];
    bit r_active[2], r_nolast[2], r_rnd[2];

    function automatic logic [N-1:0] prog_sum(input int i, input int len);
        logic [31:0] acc = 32'd0;
        for (int a = 0; a < len; a++) acc = acc + 32'(prog[i][a]) * 32'(a + 1);
        return acc[N-1:0];
    endfunction

    task automatic new_job(input int i, input int len, input bit nolast, input int rdelay);
        for (int a = 0; a < len; a++) prog[i][a] = N'($urandom);
        r_len[i] = len; r_idx[i] = 0; r_nolast[i] = nolast; r_rdelay[i] = rdelay;
        r_stall_at[i] = -1; r_stall_n[i] = 0; r_rnd[i] = 1'b0; r_active[i] = 1'b1;
    endtask

    task automatic drive();
        logic [1:0] v, l, rr;
        logic [N-1:0] w [2];
        for (int i = 0; i < 2; i++) begin
            v[i] = r_active[i] && (r_idx[i] < r_len[i]);
            if (v[i] && r_idx[i] == r_stall_at[i] && r_stall_n[i] > 0) begin
                v[i] = 1'b0; r_stall_n[i]--;
            end else if (v[i] && r_rnd[i] && $urandom_range(0, 3) == 0) begin
                v[i] = 1'b0;
            end
            w[i]  = v[i] ? prog[i][r_idx[i]] : N'($urandom);
            l[i]  = v[i] && !r_nolast[i] && (r_idx[i] == r_len[i] - 1);
            rr[i] = (r_rdelay[i] == 0);
        end
        jif.req_valid = v; jif.req_last = l; jif.resp_ready = rr;
        jif.req0_word = w[0]; jif.req1_word = w[1];
    endtask

    task automatic step();
        logic [1:0] acc, hs;
        @(negedge clk);
        acc = jif.req_valid & jif.req_ready;
        hs  = jif.resp_valid & jif.resp_ready;
        for (int i = 0; i < 2; i++)
            if (jif.resp_valid[i] && !jif.resp_ready[i] && r_rdelay[i] > 0) r_rdelay[i]--;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) r_idx[i]++;
            if (hs[i]) r_active[i] = 1'b0;
        end
        drive();
    endtask

    task automatic run_jobs(input int budget);
        int k = 0;
        while ((r_active[0] || r_active[1]) && k < budget) begin step(); k++; end
        check("jobs_complete", 32'(r_active[0] | r_active[1]), 32'd0);
    endtask

    task automatic do_reset();
        r_active[0] = 1'b0; r_active[1] = 1'b0;
        drive();
        nrst = 1'b0;
        #1;
        check("rst_busy", 32'(jif.busy), 32'd0);
        check("rst_grant", 32'(jif.grant), 32'd0);
        check("rst_req_ready", 32'(jif.req_ready), 32'd0);
        check("rst_resp_valid", 32'(jif.resp_valid), 32'd0);
        check("rst_resp_data", 32'(jif.resp_data), 32'd0);
        check("rst_resp_cycles", 32'(jif.resp_cycles), 32'd0);
        check("rst_calc_wr", 32'(calc_wr), 32'd0);
        check("rst_calc_start", 32'(calc_start), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int mark, gsz, k;
        jif.req_valid = 2'b00; jif.req_last = 2'b00; jif.resp_ready = 2'b00;
        jif.req0_word = '0; jif.req1_word = '0;
        #1;
        do_reset();

        // Fixed three-word program from requester 0, calculator busy 3 cycles
        new_job(0, 3, 1'b0, 0);
        prog[0][0] = 16'h0005; prog[0][1] = 16'h0007; prog[0][2] = 16'hC000;
        force_delay = 3; mark = n_start;
        drive(); run_jobs(200);
        check("s1_resp_data", 32'(jif.resp_data), 32'h4013);
        check("s1_resp_cycles", 32'(jif.resp_cycles), 32'd5);
        check("s1_start_pulses", 32'(n_start - mark), 32'd1);
        check("s1_mem_addr2", 32'(c_mem[2]), 32'h0000C000);
        force_delay = 0;

        // Both requesting from reset, twice: strict alternation starting at 0
        do_reset();
        glog.delete();
        repeat (2) begin
            new_job(0, int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(0, 2)));
            new_job(1, int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(0, 2)));
            drive(); run_jobs(400);
        end
        check("s2_grant_count", 32'(glog.size()), 32'd4);
        for (int g = 0; g < glog.size() && g < 4; g++) check("s2_grant_order", 32'(glog[g]), 32'(g % 2));

        // Four-cycle gap mid-load
        new_job(0, 8, 1'b0, 0);
        r_stall_at[0] = 3; r_stall_n[0] = 4;
        drive(); run_jobs(300);
        check("s3_stall_applied", 32'(r_stall_n[0]), 32'd0);
        check("s3_resp_data", 32'(jif.resp_data), 32'(prog_sum(0, 8)));

        // Full code memory with no last flag: word 2^M is never taken
        new_job(1, DEPTH + 1, 1'b1, 0);
        drive(); run_jobs(3 * DEPTH);
        check("s4_words_accepted", 32'(r_idx[1]), 32'(DEPTH));
        check("s4_resp_data", 32'(jif.resp_data), 32'(prog_sum(1, DEPTH)));

        // Result held for 10 cycles while requester 1 waits
        mark = n_rv0;
        new_job(0, 4, 1'b0, 10);
        new_job(1, 3, 1'b0, 0);
        drive(); run_jobs(300);
        check("s5_resp_valid_cycles", 32'(n_rv0 - mark), 32'd11);

        // Long run saturates the cycle counter
        force_delay = 70;
        new_job(1, 2, 1'b0, 0);
        drive(); run_jobs(300);
        check("s6_resp_cycles_sat", 32'(jif.resp_cycles), 32'(SAT));
        force_delay = 0;

        // Reset after two words are loaded, then a fresh job from requester 1
        new_job(0, 6, 1'b0, 0);
        drive();
        k = 0;
        while (r_idx[0] < 2 && k < 50) begin step(); k++; end
        check("s7_two_words_loaded", 32'(r_idx[0]), 32'd2);
        do_reset();
        gsz = glog.size();
        new_job(1, 4, 1'b0, 0);
        drive(); run_jobs(200);
        check("s7_new_grant", 32'(glog.size() - gsz), 32'd1);
        if (glog.size() > 0) check("s7_grant_owner", 32'(glog[glog.size()-1]), 32'd1);
        check("s7_resp_data", 32'(jif.resp_data), 32'(prog_sum(1, 4)));

        // Single-word program, then random traffic
        new_job(0, 1, 1'b0, 0);
        drive(); run_jobs(100);
        check("s8_single_word", 32'(jif.resp_data), 32'(prog_sum(0, 1)));
        repeat (8) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    new_job(i, int'($urandom_range(1, 12)), 1'b0, int'($urandom_range(0, 3)));
                    r_rnd[i] = 1'b1;
                end
            end
            drive(); run_jobs(1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
